// File: rtl/morra_match_ctrl.sv
// Two-player morra cinese match controller: scores rounds, enforces the no-repeat-winning-move
// rule and decides the match by lead margin or at a round limit fixed when the match starts.
module morra_match_ctrl #(
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned BASE_ROUNDS = 4,
  parameter int unsigned MIN_ROUNDS  = 4,
  parameter int unsigned LEAD        = 2,
  parameter int unsigned NO_REPEAT   = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       move_a_i,
  input  logic [1:0]       move_b_i,
  output logic [1:0]       round_res_o,
  output logic [1:0]       match_res_o,
  output logic [CNT_W-1:0] score_a_o,
  output logic [CNT_W-1:0] score_b_o,
  output logic [CNT_W-1:0] rounds_o,
  output logic             done_o
);

  typedef enum logic [1:0] {StIdle, StPlay, StDone} state_e;

  localparam logic signed [CNT_W:0] LeadS = (CNT_W+1)'(LEAD);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] score_a_q, score_a_d, score_b_q, score_b_d, rounds_q, rounds_d;
  logic [1:0]       last_a_q, last_a_d, last_b_q, last_b_d;
  logic [1:0]       round_res_q, round_res_d, match_res_q, match_res_d;
  logic             valid, a_wins, b_wins;
  logic signed [CNT_W:0] diff;

  function automatic logic beats(input logic [1:0] x, input logic [1:0] y);
    logic r;
    case ({x, y})
      4'b10_01, 4'b11_10, 4'b01_11: r = 1'b1;
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    max_d       = max_q;
    score_a_d   = score_a_q;
    score_b_d   = score_b_q;
    rounds_d    = rounds_q;
    last_a_d    = last_a_q;
    last_b_d    = last_b_q;
    match_res_d = match_res_q;
    round_res_d = 2'b00;
    diff        = '0;
    a_wins      = beats(move_a_i, move_b_i);
    b_wins      = beats(move_b_i, move_a_i);
    // last_* is 00 when no repeat restriction applies, and 00 moves are already invalid
    valid = (move_a_i != 2'b00) && (move_b_i != 2'b00) &&
            !((NO_REPEAT != 0) && (move_a_i == last_a_q)) &&
            !((NO_REPEAT != 0) && (move_b_i == last_b_q));

    if (start_i) begin
      state_d     = StPlay;
      max_d       = CNT_W'(BASE_ROUNDS) + CNT_W'({move_a_i, move_b_i});
      score_a_d   = '0;
      score_b_d   = '0;
      rounds_d    = '0;
      last_a_d    = 2'b00;
      last_b_d    = 2'b00;
      match_res_d = 2'b00;
    end else if (state_q == StPlay && valid) begin
      rounds_d = rounds_q + CNT_W'(1);
      if (a_wins) begin
        score_a_d   = score_a_q + CNT_W'(1);
        last_a_d    = move_a_i;
        last_b_d    = 2'b00;
        round_res_d = 2'b01;
      end else if (b_wins) begin
        score_b_d   = score_b_q + CNT_W'(1);
        last_b_d    = move_b_i;
        last_a_d    = 2'b00;
        round_res_d = 2'b10;
      end else begin
        last_a_d    = 2'b00;
        last_b_d    = 2'b00;
        round_res_d = 2'b11;
      end

      diff = $signed({1'b0, score_a_d}) - $signed({1'b0, score_b_d});
      if (rounds_d >= CNT_W'(MIN_ROUNDS) && diff >= LeadS) begin
        match_res_d = 2'b01;
        state_d     = StDone;
      end else if (rounds_d >= CNT_W'(MIN_ROUNDS) && diff <= -LeadS) begin
        match_res_d = 2'b10;
        state_d     = StDone;
      end else if (rounds_d == max_q) begin
        match_res_d = (diff > 0) ? 2'b01 : (diff < 0) ? 2'b10 : 2'b11;
        state_d     = StDone;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      max_q       <= '0;
      score_a_q   <= '0;
      score_b_q   <= '0;
      rounds_q    <= '0;
      last_a_q    <= 2'b00;
      last_b_q    <= 2'b00;
      round_res_q <= 2'b00;
      match_res_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      max_q       <= max_d;
      score_a_q   <= score_a_d;
      score_b_q   <= score_b_d;
      rounds_q    <= rounds_d;
      last_a_q    <= last_a_d;
      last_b_q    <= last_b_d;
      round_res_q <= round_res_d;
      match_res_q <= match_res_d;
    end
  end

  assign round_res_o = round_res_q;
  assign match_res_o = match_res_q;
  assign score_a_o   = score_a_q;
  assign score_b_o   = score_b_q;
  assign rounds_o    = rounds_q;
  assign done_o      = (state_q == StDone);

endmodule

// File: tb/tb_morra_match_ctrl.sv
// Bench for morra_match_ctrl: directed scenarios plus randomized play against a rule-level model.
module tb_morra_match_ctrl;

  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, start2;
  logic [1:0]    ma, mb, ma2, mb2;
  logic [1:0]    rr, mr, rr2, mr2;
  logic [CW-1:0] sa, sb, rn, sa2, sb2, rn2;
  logic          dn, dn2;
  logic [19:0]   got, exp_v;

  int vectors = 0;
  int miscompares = 0;

  // Rule-level model state
  int m_armed, m_done, m_max, m_la, m_lb, m_sa, m_sb, m_rn, m_rr, m_mr;

  morra_match_ctrl u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .move_a_i(ma), .move_b_i(mb),
    .round_res_o(rr), .match_res_o(mr), .score_a_o(sa), .score_b_o(sb),
    .rounds_o(rn), .done_o(dn)
  );

  morra_match_ctrl #(.LEAD(3), .MIN_ROUNDS(1), .NO_REPEAT(0)) u_var (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .move_a_i(ma2), .move_b_i(mb2),
    .round_res_o(rr2), .match_res_o(mr2), .score_a_o(sa2), .score_b_o(sb2),
    .rounds_o(rn2), .done_o(dn2)
  );

  always #5 clk = ~clk;

  assign got = {rr, mr, sa, sb, rn, dn};

  function automatic int beats(int x, int y);
    return int'(((x - y + 3) % 3) == 1);
  endfunction

  task automatic model_reset();
    m_armed = 0; m_done = 0; m_max = 0; m_la = 0; m_lb = 0;
    m_sa = 0; m_sb = 0; m_rn = 0; m_rr = 0; m_mr = 0;
  endtask

  task automatic model_step(input bit s, input int a, input int b);
    m_rr = 0;
    if (s) begin
      m_max = 4 + a * 4 + b;
      m_sa = 0; m_sb = 0; m_rn = 0; m_la = 0; m_lb = 0; m_mr = 0; m_done = 0; m_armed = 1;
    end else if (m_armed == 1 && m_done == 0) begin
      if (a != 0 && b != 0 && a != m_la && b != m_lb) begin
        m_rn++;
        if (beats(a, b) == 1) begin
          m_sa++; m_la = a; m_lb = 0; m_rr = 1;
        end else if (beats(b, a) == 1) begin
          m_sb++; m_lb = b; m_la = 0; m_rr = 2;
        end else begin
          m_la = 0; m_lb = 0; m_rr = 3;
        end
        if (m_rn >= 4 && (m_sa - m_sb >= 2 || m_sb - m_sa >= 2)) begin
          m_mr = (m_sa > m_sb) ? 1 : 2;
          m_done = 1;
        end else if (m_rn == m_max) begin
          m_mr = (m_sa > m_sb) ? 1 : (m_sb > m_sa) ? 2 : 3;
          m_done = 1;
        end
      end
    end
    exp_v = {2'(m_rr), 2'(m_mr), 5'(m_sa), 5'(m_sb), 5'(m_rn), 1'(m_done)};
  endtask

  // Drive one cycle, sample 1 time unit after the edge, advance the model.
  task automatic step(input bit s, input int a, input int b);
    start = s; ma = 2'(a); mb = 2'(b);
    @(posedge clk);
    #1;
    model_step(s, a, b);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ma = 2'b00; mb = 2'b00;
    start2 = 1'b0; ma2 = 2'b00; mb2 = 2'b00;
    model_reset();
    #13 rst = 1'b0;
    step(0, 1, 3);
    vectors++;
    if (got !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_no_start got=%h exp=%h", got, 20'h0);
    end
    step(1, 1, 0);
    step(0, 1, 3);
    step(0, 2, 1);
    vectors++;
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL pre_async_rst got=%h exp=%h", got, exp_v);
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (got !== 20'h0) begin
      miscompares++;
      $display("FAIL async_rst got=%h exp=%h", got, 20'h0);
    end
    #1 rst = 1'b0;
    step(0, 1, 3);
    vectors++;
    if (got !== 20'h0) begin
      miscompares++;
      $display("FAIL after_rst_needs_start got=%h exp=%h", got, 20'h0);
    end
  endtask

  task automatic test_lead_win();
    int ra[4] = '{1, 2, 3, 1};
    int rb[4] = '{3, 1, 2, 3};
    step(1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, ra[i], rb[i]);
      vectors++;
      if (rr !== 2'b01 || dn !== (i == 3) || got !== exp_v) begin
        miscompares++;
        $display("FAIL lead_round%0d got=%h exp=%h", i + 1, got, exp_v);
      end
    end
    vectors++;
    if (sa !== 5'd4 || mr !== 2'b01 || dn !== 1'b1) begin
      miscompares++;
      $display("FAIL lead_decided sa=%0d mr=%b done=%b exp 4/01/1", sa, mr, dn);
    end
    step(0, 1, 3);
    vectors++;
    if (rr !== 2'b00 || sa !== 5'd4 || got !== exp_v) begin
      miscompares++;
      $display("FAIL lead_frozen got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_repeat();
    int ra[4] = '{2, 2, 1, 2};
    int rb[4] = '{1, 3, 2, 1};
    logic [1:0] er[4] = '{2'b01, 2'b00, 2'b10, 2'b01};
    step(1, 3, 3);
    for (int i = 0; i < 4; i++) begin
      step(0, ra[i], rb[i]);
      vectors++;
      if (rr !== er[i] || got !== exp_v) begin
        miscompares++;
        $display("FAIL repeat_step%0d rr=%b exp=%b got=%h model=%h", i, rr, er[i], got, exp_v);
      end
    end
    vectors++;
    if (rn !== 5'd3) begin
      miscompares++;
      $display("FAIL repeat_rounds got=%0d exp=3", rn);
    end
  endtask

  task automatic test_ties();
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, (i % 3) + 1, (i % 3) + 1);
      vectors++;
      if (rr !== 2'b11 || got !== exp_v) begin
        miscompares++;
        $display("FAIL tie_round%0d got=%h exp=%h", i + 1, got, exp_v);
      end
    end
    vectors++;
    if (mr !== 2'b11 || dn !== 1'b1) begin
      miscompares++;
      $display("FAIL tie_draw mr=%b done=%b exp 11/1", mr, dn);
    end
  endtask

  task automatic test_limit_restart();
    step(1, 0, 0);
    step(0, 1, 3);
    step(0, 2, 2);
    step(0, 3, 3);
    step(0, 1, 1);
    vectors++;
    if (rn !== 5'd4 || sa !== 5'd1 || sb !== 5'd0 || mr !== 2'b01 || dn !== 1'b1) begin
      miscompares++;
      $display("FAIL limit_tiebreak got=%h exp=%h", got, exp_v);
    end
    step(1, 0, 1);
    vectors++;
    if (got !== 20'h0) begin
      miscompares++;
      $display("FAIL restart_clear got=%h exp=%h", got, 20'h0);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, (i % 3) + 1, (i % 3) + 1);
      vectors++;
      if (dn !== (i == 4) || got !== exp_v) begin
        miscompares++;
        $display("FAIL restart_limit5_round%0d got=%h exp=%h", i + 1, got, exp_v);
      end
    end
  endtask

  task automatic test_variant();
    start2 = 1'b1; ma2 = 2'b00; mb2 = 2'b00;
    @(posedge clk);
    #1;
    start2 = 1'b0; ma2 = 2'b01; mb2 = 2'b11;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (rr2 !== 2'b01 || rn2 !== 5'(i) || sa2 !== 5'(i) || dn2 !== (i == 3) ||
          mr2 !== ((i == 3) ? 2'b01 : 2'b00)) begin
        miscompares++;
        $display("FAIL variant_round%0d rr=%b rn=%0d sa=%0d mr=%b done=%b", i, rr2, rn2, sa2,
                 mr2, dn2);
      end
    end
    ma2 = 2'b00; mb2 = 2'b00;
  endtask

  task automatic test_random();
    step(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 24) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL random_cycle%0d got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lead_win();
    test_repeat();
    test_ties();
    test_limit_restart();
    test_variant();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
